// File: rtl/dreg_rr_arbiter_if.sv
// rtl/dreg_rr_arbiter_if.sv - requester/register-bank bundle between lab logic and dreg_rr_arbiter
// q_par is present only when DREG_PARITY_EN is defined.
interface dreg_rr_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
);
   localparam int OW = $clog2(NREQ);

   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] wdata;
   logic [NREQ-1:0]       gnt;
   logic                  ack;
   logic [OW-1:0]         owner;
   logic                  busy;
   logic [WIDTH-1:0]      q;
   logic [WIDTH-1:0]      notq;
`ifdef DREG_PARITY_EN
   logic                  q_par;
`endif

   modport slave (
`ifdef DREG_PARITY_EN
      output q_par,
`endif
      input  req, wdata,
      output gnt, ack, owner, busy, q, notq
   );

   modport master (
`ifdef DREG_PARITY_EN
      input  q_par,
`endif
      output req, wdata,
      input  gnt, ack, owner, busy, q, notq
   );
endinterface

// File: rtl/dreg_rr_arbiter.sv
// rtl/dreg_rr_arbiter.sv - round-robin arbiter sharing one WIDTH-bit D-register bank among NREQ requesters
// Define DREG_PARITY_EN to add the registered even-parity output q_par.
module dreg_rr_arbiter #(
   parameter int NREQ        = 4,
   parameter int WIDTH       = 8,
   parameter int HOLD_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   dreg_rr_arbiter_if.slave bus
);
   localparam int OW = $clog2(NREQ);

   typedef enum logic [1:0] {IDLE, GRANT, ACK} state_e;

   state_e           state_q;
   logic [NREQ-1:0]  gnt_q;
   logic             ack_q;
   logic [OW-1:0]    owner_q;
   logic [OW-1:0]    ptr_q;
   logic [3:0]       cnt_q;
   logic [WIDTH-1:0] q_q;
   logic [OW-1:0]    sel_d;
   logic [OW-1:0]    owner_inc;
   logic [WIDTH-1:0] wsel;
`ifdef DREG_PARITY_EN
   logic             par_q;
`endif

   // First requester at or after ptr, wrapping modulo NREQ.
   always_comb begin
      logic          found;
      logic [OW-1:0] idx;
      sel_d = ptr_q;
      found = 1'b0;
      idx   = '0;
      for (int k = 0; k < NREQ; k++) begin
         idx = OW'((int'(ptr_q) + k) % NREQ);
         if (!found && bus.req[idx]) begin
            found = 1'b1;
            sel_d = idx;
         end
      end
   end

   always_comb begin
      wsel = bus.wdata[WIDTH-1:0];
      for (int i = 0; i < NREQ; i++) begin
         if (owner_q == OW'(i)) wsel = bus.wdata[i*WIDTH +: WIDTH];
      end
   end

   assign owner_inc = (owner_q == OW'(NREQ-1)) ? '0 : owner_q + 1'b1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         ack_q   <= 1'b0;
         owner_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         q_q     <= '0;
`ifdef DREG_PARITY_EN
         par_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               if (|bus.req) begin
                  gnt_q   <= {{(NREQ-1){1'b0}}, 1'b1} << sel_d;
                  owner_q <= sel_d;
                  cnt_q   <= '0;
                  state_q <= GRANT;
               end
            end
            GRANT: begin
               // A dropped request abandons the write and passes the turn on.
               if (!bus.req[owner_q]) begin
                  gnt_q   <= '0;
                  ptr_q   <= owner_inc;
                  state_q <= IDLE;
               end else if (cnt_q == 4'(HOLD_CYCLES-1)) begin
                  q_q     <= wsel;
`ifdef DREG_PARITY_EN
                  par_q   <= ^wsel;
`endif
                  ack_q   <= 1'b1;
                  state_q <= ACK;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            ACK: begin
               ack_q   <= 1'b0;
               gnt_q   <= '0;
               ptr_q   <= owner_inc;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.gnt   = gnt_q;
   assign bus.ack   = ack_q;
   assign bus.owner = owner_q;
   assign bus.busy  = (state_q != IDLE);
   assign bus.q     = q_q;
   assign bus.notq  = ~q_q;
`ifdef DREG_PARITY_EN
   assign bus.q_par = par_q;
`endif
endmodule

// File: tb/tb_dreg_rr_arbiter.sv
// tb/tb_dreg_rr_arbiter.sv - directed self-checking bench for dreg_rr_arbiter (NREQ=4, WIDTH=8, HOLD_CYCLES=2)
// Parity checks are compiled in when DREG_PARITY_EN is defined.
module tb_dreg_rr_arbiter;
   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_fail;

   dreg_rr_arbiter_if #(.NREQ(4), .WIDTH(8)) bus();

   dreg_rr_arbiter #(.NREQ(4), .WIDTH(8), .HOLD_CYCLES(2)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_lane(input int i, input logic [7:0] v);
      bus.wdata[i*8 +: 8] = v;
   endtask

   task automatic do_reset();
      rst_n   = 1'b0;
      bus.req = '0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      bus.req   = '0;
      bus.wdata = '0;
      rst_n     = 1'b0;
      #2;
      n_checks++; if (bus.q !== 8'h00) begin n_fail++; $display("FAIL reset_q got %h exp 00", bus.q); end
      n_checks++; if (bus.notq !== 8'hFF) begin n_fail++; $display("FAIL reset_notq got %h exp ff", bus.notq); end
      n_checks++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt got %b exp 0000", bus.gnt); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
      n_checks++; if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got %b exp 0", bus.ack); end
      n_checks++; if (bus.owner !== 2'd0) begin n_fail++; $display("FAIL reset_owner got %0d exp 0", bus.owner); end
`ifdef DREG_PARITY_EN
      n_checks++; if (bus.q_par !== 1'b0) begin n_fail++; $display("FAIL reset_qpar got %b exp 0", bus.q_par); end
`endif
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_single();
      set_lane(2, 8'hA5);
      bus.req = 4'b0100;
      step(); // E0
      n_checks++; if (bus.gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt_e0 got %b exp 0100", bus.gnt); end
      n_checks++; if (bus.owner !== 2'd2) begin n_fail++; $display("FAIL single_owner got %0d exp 2", bus.owner); end
      n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_e0 got %b exp 1", bus.busy); end
      step(); // E1
      n_checks++; if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL single_ack_e1 got %b exp 0", bus.ack); end
      n_checks++; if (bus.q !== 8'h00) begin n_fail++; $display("FAIL single_q_e1 got %h exp 00", bus.q); end
      step(); // E2
      n_checks++; if (bus.ack !== 1'b1) begin n_fail++; $display("FAIL single_ack_e2 got %b exp 1", bus.ack); end
      n_checks++; if (bus.q !== 8'hA5) begin n_fail++; $display("FAIL single_q got %h exp a5", bus.q); end
      n_checks++; if (bus.notq !== 8'h5A) begin n_fail++; $display("FAIL single_notq got %h exp 5a", bus.notq); end
      n_checks++; if (bus.gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt_e2 got %b exp 0100", bus.gnt); end
      bus.req = 4'b0000;
      step(); // E3
      n_checks++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL single_gnt_e3 got %b exp 0000", bus.gnt); end
      n_checks++; if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL single_ack_e3 got %b exp 0", bus.ack); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_e3 got %b exp 0", bus.busy); end
      n_checks++; if (bus.owner !== 2'd2) begin n_fail++; $display("FAIL single_owner_idle got %0d exp 2", bus.owner); end
   endtask

   task automatic test_round_robin();
      logic [7:0] data [4];
      int         order [5];
      data  = '{8'h11, 8'h22, 8'h33, 8'h44};
      order = '{0, 1, 2, 3, 0};
      do_reset();
      for (int i = 0; i < 4; i++) set_lane(i, data[i]);
      bus.req = 4'b1111;
      for (int t = 0; t < 5; t++) begin
         logic [3:0] exp_gnt;
         exp_gnt = 4'b0001 << order[t];
         step();
         n_checks++; if (bus.gnt !== exp_gnt) begin n_fail++; $display("FAIL rr_gnt[%0d] got %b exp %b", t, bus.gnt, exp_gnt); end
         n_checks++; if (bus.owner !== 2'(order[t])) begin n_fail++; $display("FAIL rr_owner[%0d] got %0d exp %0d", t, bus.owner, order[t]); end
         step();
         step();
         n_checks++; if (bus.ack !== 1'b1) begin n_fail++; $display("FAIL rr_ack[%0d] got %b exp 1", t, bus.ack); end
         n_checks++; if (bus.q !== data[order[t]]) begin n_fail++; $display("FAIL rr_q[%0d] got %h exp %h", t, bus.q, data[order[t]]); end
         step();
         n_checks++; if (bus.gnt !== 4'b0000 || bus.ack !== 1'b0) begin n_fail++; $display("FAIL rr_idle[%0d] gnt %b ack %b exp 0000 0", t, bus.gnt, bus.ack); end
      end
      bus.req = 4'b0000;
   endtask

   // Entered with ptr=1 and q=8'h11 left by the round-robin run.
   task automatic test_abort();
      set_lane(1, 8'hBB);
      set_lane(2, 8'hCC);
      bus.req = 4'b0110;
      step(); // E0
      n_checks++; if (bus.gnt !== 4'b0010) begin n_fail++; $display("FAIL abort_gnt got %b exp 0010", bus.gnt); end
      bus.req = 4'b0100;
      step(); // E1: abort
      n_checks++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL abort_gnt_clr got %b exp 0000", bus.gnt); end
      n_checks++; if (bus.ack !== 1'b0) begin n_fail++; $display("FAIL abort_ack got %b exp 0", bus.ack); end
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b exp 0", bus.busy); end
      n_checks++; if (bus.q !== 8'h11) begin n_fail++; $display("FAIL abort_q got %h exp 11", bus.q); end
      step(); // E2
      n_checks++; if (bus.gnt !== 4'b0100) begin n_fail++; $display("FAIL abort_next_gnt got %b exp 0100", bus.gnt); end
      bus.req = 4'b0000;
      step(); // second abort, ptr becomes 3
      n_checks++; if (bus.gnt !== 4'b0000 || bus.ack !== 1'b0) begin n_fail++; $display("FAIL abort2 gnt %b ack %b exp 0000 0", bus.gnt, bus.ack); end
      n_checks++; if (bus.q !== 8'h11) begin n_fail++; $display("FAIL abort2_q got %h exp 11", bus.q); end
   endtask

   task automatic test_reset_mid_grant();
      set_lane(0, 8'h5C);
      set_lane(3, 8'h3D);
      bus.req = 4'b1000;
      step();
      n_checks++; if (bus.gnt !== 4'b1000) begin n_fail++; $display("FAIL midrst_pre_gnt got %b exp 1000", bus.gnt); end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL midrst_gnt got %b exp 0000", bus.gnt); end
      n_checks++; if (bus.q !== 8'h00 || bus.notq !== 8'hFF) begin n_fail++; $display("FAIL midrst_q got %h/%h exp 00/ff", bus.q, bus.notq); end
      n_checks++; if (bus.busy !== 1'b0 || bus.ack !== 1'b0) begin n_fail++; $display("FAIL midrst_busy_ack got %b %b exp 0 0", bus.busy, bus.ack); end
      bus.req = 4'b1001;
      step();
      n_checks++; if (bus.gnt !== 4'b0000) begin n_fail++; $display("FAIL midrst_held got %b exp 0000", bus.gnt); end
      rst_n = 1'b1;
      step();
      n_checks++; if (bus.gnt !== 4'b0001) begin n_fail++; $display("FAIL midrst_next_gnt got %b exp 0001", bus.gnt); end
      n_checks++; if (bus.owner !== 2'd0) begin n_fail++; $display("FAIL midrst_owner got %0d exp 0", bus.owner); end
      step();
      step();
      n_checks++; if (bus.ack !== 1'b1 || bus.q !== 8'h5C) begin n_fail++; $display("FAIL midrst_write ack %b q %h exp 1 5c", bus.ack, bus.q); end
      bus.req = 4'b0000;
      step();
   endtask

`ifdef DREG_PARITY_EN
   task automatic test_parity();
      logic [7:0] vals [2];
      logic       pars [2];
      vals = '{8'h07, 8'h03};
      pars = '{1'b1, 1'b0};
      for (int t = 0; t < 2; t++) begin
         set_lane(0, vals[t]);
         bus.req = 4'b0001;
         step();
         step();
         step();
         n_checks++; if (bus.q !== vals[t]) begin n_fail++; $display("FAIL parity_q[%0d] got %h exp %h", t, bus.q, vals[t]); end
         n_checks++; if (bus.q_par !== pars[t]) begin n_fail++; $display("FAIL parity_bit[%0d] got %b exp %b", t, bus.q_par, pars[t]); end
         bus.req = 4'b0000;
         step();
      end
   endtask
`endif

   initial begin
      n_checks = 0;
      n_fail   = 0;
      test_reset();
      test_single();
      test_round_robin();
      test_abort();
      test_reset_mid_grant();
`ifdef DREG_PARITY_EN
      test_parity();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
